// File: rtl/dmem_ctrl_if.sv
// Request/response bus between a load/store unit and the data memory controller.
// Handshake: a request is transferred on a rising edge where req_i && ready_o;
// the requester holds all request fields stable until that edge. rvalid_o and
// err_o are single-cycle pulses in the cycle after the accepting edge.
interface dmem_ctrl_if;
    logic        req_i;
    logic        we_i;
    logic [1:0]  size_i;
    logic        unsigned_i;
    logic [31:0] addr_i;
    logic [31:0] wdata_i;
    logic        ready_o;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        err_o;

    modport master (
        output req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        input  ready_o, rvalid_o, rdata_o, err_o
    );

    modport slave (
        input  req_i, we_i, size_i, unsigned_i, addr_i, wdata_i,
        output ready_o, rvalid_o, rdata_o, err_o
    );
endinterface

// File: rtl/dmem_ctrl.sv
// Word-organised data memory with byte/half/word loads and stores.
// Word stores write directly; sub-word stores take one extra read-modify-write
// cycle during which the controller is not ready. Loads return one cycle later.
module dmem_ctrl #(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_4000,
    parameter int          DEPTH_WORDS = 16384
) (
    input  logic        clk_i,
    input  logic        rst_i,
    dmem_ctrl_if.slave  bus,
    output logic        o_dbg_state
);
    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [31:0] MEM_BYTES = 32'(4 * DEPTH_WORDS);

    typedef enum logic {
        IDLE = 1'b0,
        RMW  = 1'b1
    } state_t;

    logic [31:0]   r_mem [DEPTH_WORDS];

    state_t        r_state;
    logic          r_ready;
    logic          r_rvalid;
    logic          r_err;
    logic [31:0]   r_rdata;
    logic [AW-1:0] r_idx;
    logic [3:0]    r_mask;
    logic [31:0]   r_data;

    logic [31:0]   w_offset;
    logic          w_in_range;
    logic          w_misalign;
    logic          w_fault;
    logic          w_accept;
    logic          w_word_store;
    logic [AW-1:0] w_idx;
    logic [31:0]   w_rd_word;
    logic [31:0]   w_rd_shift;
    logic [31:0]   w_load_ext;
    logic [3:0]    w_lane_mask;
    logic [31:0]   w_lane_data;
    logic [31:0]   w_rmw_word;
    logic [31:0]   w_merged;

    assign w_offset     = bus.addr_i - BASE_ADDR;
    assign w_in_range   = (bus.addr_i >= BASE_ADDR) && (w_offset < MEM_BYTES);
    assign w_misalign   = ((bus.size_i == 2'b01) && bus.addr_i[0]) ||
                          ((bus.size_i == 2'b10) && (bus.addr_i[1:0] != 2'b00));
    assign w_fault      = !w_in_range || w_misalign || (bus.size_i == 2'b11);
    assign w_accept     = bus.req_i && r_ready;
    assign w_word_store = w_accept && bus.we_i && !w_fault && (bus.size_i == 2'b10);
    assign w_idx        = w_offset[AW+1:2];
    assign w_rd_word    = r_mem[w_idx];
    assign w_rmw_word   = r_mem[r_idx];
    // Alignment is guaranteed for legal halves, so one byte-granular shift serves both sizes.
    assign w_rd_shift   = w_rd_word >> {w_offset[1:0], 3'b000};

    // Extend the addressed byte/half of the read word to 32 bits.
    always_comb begin
        w_load_ext = w_rd_word;
        case (bus.size_i)
            2'b00:   w_load_ext = bus.unsigned_i ? {24'h0, w_rd_shift[7:0]}
                                                 : {{24{w_rd_shift[7]}}, w_rd_shift[7:0]};
            2'b01:   w_load_ext = bus.unsigned_i ? {16'h0, w_rd_shift[15:0]}
                                                 : {{16{w_rd_shift[15]}}, w_rd_shift[15:0]};
            default: w_load_ext = w_rd_word;
        endcase
    end

    // Lane mask and lane-replicated data for a sub-word store, plus the merged word in RMW.
    always_comb begin
        if (bus.size_i == 2'b01) begin
            w_lane_mask = 4'b0011 << {w_offset[1], 1'b0};
            w_lane_data = {2{bus.wdata_i[15:0]}};
        end else begin
            w_lane_mask = 4'b0001 << w_offset[1:0];
            w_lane_data = {4{bus.wdata_i[7:0]}};
        end
        for (int i = 0; i < 4; i++) begin
            w_merged[8*i +: 8] = r_mask[i] ? r_data[8*i +: 8] : w_rmw_word[8*i +: 8];
        end
    end

    // Memory array writes; never cleared, and a reset edge suppresses any pending write.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (w_word_store) begin
                r_mem[w_idx] <= bus.wdata_i;
            end else if (r_state == RMW) begin
                r_mem[r_idx] <= w_merged;
            end
        end
    end

    // Control FSM with registered handshake and response outputs.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_state  <= IDLE;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
            r_idx    <= '0;
            r_mask   <= 4'h0;
            r_data   <= 32'h0;
        end else begin
            r_rvalid <= 1'b0;
            r_err    <= 1'b0;
            r_rdata  <= 32'h0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        if (w_fault) begin
                            r_err    <= 1'b1;
                            r_rvalid <= !bus.we_i;
                        end else if (!bus.we_i) begin
                            r_rvalid <= 1'b1;
                            r_rdata  <= w_load_ext;
                        end else if (bus.size_i != 2'b10) begin
                            r_state <= RMW;
                            r_ready <= 1'b0;
                            r_idx   <= w_idx;
                            r_mask  <= w_lane_mask;
                            r_data  <= w_lane_data;
                        end
                    end
                end
                RMW: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
                default: begin
                    r_state <= IDLE;
                    r_ready <= 1'b1;
                end
            endcase
        end
    end

    assign bus.ready_o  = r_ready;
    assign bus.rvalid_o = r_rvalid;
    assign bus.err_o    = r_err;
    assign bus.rdata_o  = r_rdata;
    assign o_dbg_state  = r_state;
endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl: directed scenarios plus a randomized
// load/store mix checked against a byte-addressed reference memory.
module tb_dmem_ctrl;
    localparam logic [31:0] BASE  = 32'h0000_4000;
    localparam int          DEPTH = 16384;
    localparam logic [31:0] TOP   = BASE + 32'(4 * DEPTH);

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst;
    logic dbg_state;
    always #5 clk = ~clk;

    dmem_ctrl_if bus ();

    dmem_ctrl #(
        .BASE_ADDR   (BASE),
        .DEPTH_WORDS (DEPTH)
    ) u_dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .bus         (bus),
        .o_dbg_state (dbg_state)
    );

    // ---------------- scoreboard state ----------------
    int          n_chk = 0;
    int          n_err = 0;
    logic [33:0] exp_q[$];               // {rvalid, err, rdata}
    logic [7:0]  mdl [logic [31:0]];     // reference memory, byte addressed
    logic        mon_en   = 1'b0;
    logic        acc_prev = 1'b0;

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    function automatic logic is_fault(input logic [1:0] size, input logic [31:0] addr);
        logic bad;
        bad = (size == 2'b11) || (addr < BASE) || (addr >= TOP);
        if (size == 2'b01 && addr[0]) bad = 1'b1;
        if (size == 2'b10 && addr[1:0] != 2'b00) bad = 1'b1;
        return bad;
    endfunction

    function automatic logic [7:0] mdl_byte(input logic [31:0] a);
        if (mdl.exists(a)) return mdl[a];
        return 8'h00;
    endfunction

    function automatic logic [31:0] mdl_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr);
        logic [7:0]  b;
        logic [15:0] h;
        b = mdl_byte(addr);
        h = {mdl_byte(addr + 32'd1), mdl_byte(addr)};
        case (size)
            2'b00:   return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01:   return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return {mdl_byte(addr + 32'd3), mdl_byte(addr + 32'd2), h};
        endcase
    endfunction

    // ---------------- driver tasks ----------------
    // Present a request at a falling edge and hold it until the DUT is ready;
    // the expectation is queued for the response cycle after acceptance.
    task automatic drive_req(input logic we, input logic [1:0] size, input logic uns,
                             input logic [31:0] addr, input logic [31:0] wdata,
                             input logic use_exp, input logic [31:0] exp_data);
        int          waited;
        logic [31:0] ld;
        waited = 0;
        @(negedge clk);
        bus.req_i      = 1'b1;
        bus.we_i       = we;
        bus.size_i     = size;
        bus.unsigned_i = uns;
        bus.addr_i     = addr;
        bus.wdata_i    = wdata;
        while (!bus.ready_o && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        check("ready_within_bound", bus.ready_o, 1);
        if (!bus.ready_o) begin
            bus.req_i = 1'b0;
            return;
        end
        if (is_fault(size, addr)) begin
            exp_q.push_back({!we, 1'b1, 32'h0});
        end else if (!we) begin
            ld = use_exp ? exp_data : mdl_load(size, uns, addr);
            exp_q.push_back({1'b1, 1'b0, ld});
        end else begin
            mdl[addr] = wdata[7:0];
            if (size != 2'b00) mdl[addr + 32'd1] = wdata[15:8];
            if (size == 2'b10) begin
                mdl[addr + 32'd2] = wdata[23:16];
                mdl[addr + 32'd3] = wdata[31:24];
            end
            exp_q.push_back({1'b0, 1'b0, 32'h0});
        end
    endtask

    task automatic idle();
        @(negedge clk);
        bus.req_i = 1'b0;
    endtask

    // ---------------- response monitor ----------------
    always @(posedge clk) begin
        acc_prev <= mon_en && bus.req_i && bus.ready_o && !rst;
    end

    always @(negedge clk) begin
        logic [33:0] e;
        if (mon_en) begin
            if (acc_prev) begin
                if (exp_q.size() == 0) begin
                    check("resp_without_expectation", exp_q.size(), 1);
                end else begin
                    e = exp_q.pop_front();
                    check("resp", {bus.rvalid_o, bus.err_o, bus.rdata_o}, e);
                end
            end else begin
                check("no_resp_when_idle", {bus.rvalid_o, bus.err_o}, 2'b00);
            end
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        logic [31:0] a;
        logic [31:0] d;
        logic [1:0]  sz;
        rst            = 1'b1;
        bus.req_i      = 1'b0;
        bus.we_i       = 1'b0;
        bus.size_i     = 2'b00;
        bus.unsigned_i = 1'b0;
        bus.addr_i     = 32'h0;
        bus.wdata_i    = 32'h0;
        repeat (3) @(negedge clk);
        check("rst_ready",  bus.ready_o, 1);
        check("rst_rvalid", bus.rvalid_o, 0);
        check("rst_err",    bus.err_o, 0);
        check("rst_rdata",  bus.rdata_o, 0);
        check("rst_state",  dbg_state, 0);
        rst    = 1'b0;
        mon_en = 1'b1;

        // Sign/zero extension of byte and half loads
        drive_req(1, 2'b10, 0, 32'h4000, 32'h8123_45F6, 0, 0);
        drive_req(0, 2'b00, 0, 32'h4000, 0, 1, 32'hFFFF_FFF6);
        drive_req(0, 2'b00, 1, 32'h4000, 0, 1, 32'h0000_00F6);
        drive_req(0, 2'b01, 0, 32'h4002, 0, 1, 32'hFFFF_8123);
        drive_req(0, 2'b01, 1, 32'h4002, 0, 1, 32'h0000_8123);
        drive_req(0, 2'b00, 1, 32'h4003, 0, 1, 32'h0000_0081);
        drive_req(0, 2'b10, 1, 32'h4000, 0, 1, 32'h8123_45F6);
        idle();

        // Half store over zero: one not-ready cycle, then merged word
        drive_req(1, 2'b10, 0, 32'h4004, 32'h0, 0, 0);
        drive_req(1, 2'b01, 0, 32'h4006, 32'h0000_BEEF, 0, 0);
        idle();
        check("rmw_ready_low", bus.ready_o, 0);
        check("rmw_state",     dbg_state, 1);
        drive_req(0, 2'b10, 0, 32'h4004, 0, 1, 32'hBEEF_0000);
        idle();

        // Faults: misaligned, below base, illegal size, misaligned store
        drive_req(0, 2'b10, 0, 32'h4002, 0, 0, 0);
        drive_req(1, 2'b10, 0, 32'h3FFC, 32'hDEAD_BEEF, 0, 0);
        drive_req(0, 2'b11, 0, 32'h4000, 0, 0, 0);
        drive_req(1, 2'b01, 0, 32'h4001, 32'h0000_1234, 0, 0);
        drive_req(0, 2'b00, 0, 32'h3FFF, 0, 0, 0);
        drive_req(0, 2'b10, 0, 32'h4000, 0, 1, 32'h8123_45F6);
        idle();

        // Byte store followed at once by a load of the same word
        drive_req(1, 2'b10, 0, 32'h4008, 32'h1122_3344, 0, 0);
        drive_req(1, 2'b00, 0, 32'h400A, 32'h0000_00A5, 0, 0);
        drive_req(0, 2'b10, 0, 32'h4008, 0, 1, 32'h11A5_3344);
        idle();

        // Reset during RMW aborts the merge
        drive_req(1, 2'b10, 0, 32'h400C, 32'hCAFE_F00D, 0, 0);
        drive_req(1, 2'b00, 0, 32'h400D, 32'h0000_0077, 0, 0);
        @(negedge clk);
        bus.req_i = 1'b0;
        rst       = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("abort_ready",  bus.ready_o, 1);
        check("abort_rvalid", bus.rvalid_o, 0);
        check("abort_err",    bus.err_o, 0);
        check("abort_rdata",  bus.rdata_o, 0);
        check("abort_state",  dbg_state, 0);
        mdl[32'h400D] = 8'hF0;
        drive_req(0, 2'b10, 0, 32'h400C, 0, 1, 32'hCAFE_F00D);
        idle();

        // Eight back-to-back loads, and the top of the address range
        for (int i = 0; i < 8; i++) begin
            drive_req(1, 2'b10, 0, BASE + 32'(4 * i), $urandom, 0, 0);
        end
        for (int i = 0; i < 8; i++) begin
            drive_req(0, 2'b10, 0, BASE + 32'(4 * i), 0, 0, 0);
        end
        drive_req(1, 2'b10, 0, TOP - 32'd4, 32'h5A5A_0FF0, 0, 0);
        drive_req(0, 2'b10, 0, TOP - 32'd4, 0, 1, 32'h5A5A_0FF0);
        drive_req(0, 2'b00, 1, TOP - 32'd1, 0, 1, 32'h0000_005A);
        drive_req(0, 2'b10, 0, TOP, 0, 0, 0);
        idle();

        // Randomized mix in a small window, checked against the byte model
        for (int i = 0; i < 16; i++) begin
            drive_req(1, 2'b10, 0, 32'h4100 + 32'(4 * i), $urandom, 0, 0);
        end
        for (int i = 0; i < 200; i++) begin
            a  = 32'h4100 + 32'($urandom_range(0, 63));
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            if ($urandom_range(0, 19) == 0) a = TOP + 32'($urandom_range(0, 7));
            d  = $urandom;
            drive_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)), a, d, 0, 0);
            if ($urandom_range(0, 3) == 0) idle();
        end
        idle();

        repeat (3) @(negedge clk);
        check("queue_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

    // Hard time limit in case the stimulus ever stalls.
    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/dmem_ctrl.md
DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 The module SHALL have parameter BASE_ADDR, default 32'h0000_4000, meaning the byte address of word 0.
REQ-002 The module SHALL have parameter DEPTH_WORDS, default 16384, a power of two, meaning the number of 32-bit words; AW = log2(DEPTH_WORDS).
REQ-003 The module SHALL have port clk_i, input, 1 bit, the single clock; all state updates on the rising edge.
REQ-004 The module SHALL have port rst_i, input, 1 bit, a synchronous, active-high reset.
REQ-005 The module SHALL have port req_i, input, 1 bit, request valid.
REQ-006 The module SHALL have port we_i, input, 1 bit: 1 = store, 0 = load.
REQ-007 The module SHALL have port size_i, input, 2 bits: 00 byte, 01 half, 10 word, 11 illegal.
REQ-008 The module SHALL have port unsigned_i, input, 1 bit: 1 = zero-extend loads, 0 = sign-extend loads.
REQ-009 The module SHALL have port addr_i, input, 32 bits, byte address.
REQ-010 The module SHALL have port wdata_i, input, 32 bits, store data, right-aligned.
REQ-011 The module SHALL have port ready_o, output, 1 bit: a request is accepted in a cycle with req_i && ready_o.
REQ-012 The module SHALL have port rvalid_o, output, 1 bit, a one-cycle pulse marking a load response.
REQ-013 The module SHALL have port rdata_o, output, 32 bits, extended load data, valid while rvalid_o=1.
REQ-014 The module SHALL have port err_o, output, 1 bit, a one-cycle fault pulse.

Function
REQ-015 Offset SHALL be addr_i - BASE_ADDR; in-range iff addr_i >= BASE_ADDR and offset < 4*DEPTH_WORDS; word index = offset[AW+1:2].
REQ-016 Misaligned SHALL mean: half with addr_i[0]=1, or word with addr_i[1:0]!=0; size_i=11 SHALL be a fault.
REQ-017 A faulting accepted request (out-of-range, misaligned, or illegal size) SHALL NOT modify memory; err_o=1 in the next cycle; for loads also rvalid_o=1 with rdata_o=0.
REQ-018 Load latency SHALL be 1 cycle: a load accepted in cycle T drives rvalid_o=1 and rdata_o in T+1; back-to-back loads SHALL sustain one per cycle.
REQ-019 Load data SHALL select the byte or half by offset[1:0] and extend it to 32 bits per unsigned_i; word loads SHALL ignore unsigned_i.
REQ-020 A word store SHALL write the memory at the accepting edge; ready_o SHALL stay 1.
REQ-021 A byte or half store SHALL use a two-state FSM IDLE -> RMW -> IDLE. At acceptance it SHALL capture the index, lane mask and data. In RMW it SHALL read the word, merge the masked lanes and write the word. ready_o=0 in RMW.
REQ-022 ready_o SHALL be 1 in IDLE and 0 in RMW; the FSM SHALL leave RMW unconditionally after one cycle.
REQ-023 A load accepted in the cycle immediately after an RMW completes SHALL return the merged data (no stale read).
REQ-024 Stores SHALL never assert rvalid_o; err_o and rvalid_o SHALL be 0 when no request was accepted in the prior cycle.
REQ-025 req_i while ready_o=0 SHALL be ignored; the requester holds the request until accepted.

Reset
REQ-026 When rst_i=1 the module SHALL set state to IDLE, ready_o=1 after the edge, rvalid_o=0, err_o=0, rdata_o=0.
REQ-027 rst_i during RMW SHALL abort the pending merge; that memory word SHALL remain unmodified.
REQ-028 Memory contents SHALL NOT be cleared by reset.
REQ-029 rst_i SHALL take priority over any simultaneous request.

Verification
REQ-030 Scenario: store word 32'h8123_45F6 @0x4000, then load byte 0x4000 signed -> rvalid_o next cycle, rdata_o=32'hFFFF_FFF6; unsigned -> 32'h0000_00F6.
REQ-031 Scenario: store half 16'hBEEF @0x4006 over a word of 0 -> ready_o low 1 cycle; load word 0x4004 -> 32'hBEEF_0000.
REQ-032 Scenario: load word @0x4002 -> err_o=1, rvalid_o=1, rdata_o=0; store @0x3FFC -> err_o=1, memory unchanged.
REQ-033 Scenario: store byte then load the same word in the first ready cycle -> merged value returned.
REQ-034 Scenario: assert rst_i during RMW -> target word unchanged; ready_o=1 and all other outputs 0 after the edge.
REQ-035 Scenario: 8 back-to-back loads 0x4000..0x401C -> 8 consecutive rvalid_o pulses in order; last address 0x4000+4*DEPTH_WORDS-4 accepted, next word -> err_o=1.
